// File: rtl/axi4_rdwr_pipe_stage.sv
// AXI4 register slice: one 2-entry skid buffer per channel (AW, W, B, AR, R).
// MODE picks which halves exist; absent halves are tied off to idle.

module axi4_skid_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_pl,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_pl,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] m_pl_reg, m_pl_next;
  logic [WIDTH-1:0] s_pl_reg, s_pl_next;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             in_fire;
  logic             out_fire;

  assign in_fire  = in_valid & in_ready_reg;
  assign out_fire = out_valid_reg & out_ready;

  always_comb begin
    state_next = state_reg;
    m_pl_next  = m_pl_reg;
    s_pl_next  = s_pl_reg;
    case (state_reg)
      ST_EMPTY: begin
        if (in_fire) begin
          m_pl_next  = in_pl;
          state_next = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          m_pl_next = in_pl;
        end else if (in_fire) begin
          // Output stalled: park the new beat in the skid register.
          s_pl_next  = in_pl;
          state_next = ST_FULL;
        end else if (out_fire) begin
          state_next = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          m_pl_next  = s_pl_reg;
          s_pl_next  = '0;
          state_next = ST_ONE;
        end
      end
      default: begin
        state_next = ST_EMPTY;
      end
    endcase
  end

  // Flags are registered from the next state so no valid->ready path exists.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_EMPTY;
      m_pl_reg      <= '0;
      s_pl_reg      <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      m_pl_reg      <= m_pl_next;
      s_pl_reg      <= s_pl_next;
      in_ready_reg  <= (state_next != ST_FULL);
      out_valid_reg <= (state_next != ST_EMPTY);
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_pl    = m_pl_reg;

endmodule

module axi4_rdwr_pipe_stage #(
  parameter string MODE   = "BOTH",
  parameter int    IDSIZE = 4,
  parameter int    ASIZE  = 32,
  parameter int    LSIZE  = 8,
  parameter int    DSIZE  = 64
) (
  input  logic                            axi_aclk,
  input  logic                            axi_aresetn,
  // AW
  input  logic [IDSIZE+ASIZE+LSIZE+5-1:0] s_aw_pl,
  input  logic                            s_awvalid,
  output logic                            s_awready,
  output logic [IDSIZE+ASIZE+LSIZE+5-1:0] m_aw_pl,
  output logic                            m_awvalid,
  input  logic                            m_awready,
  // W
  input  logic [DSIZE+DSIZE/8+1-1:0]      s_w_pl,
  input  logic                            s_wvalid,
  output logic                            s_wready,
  output logic [DSIZE+DSIZE/8+1-1:0]      m_w_pl,
  output logic                            m_wvalid,
  input  logic                            m_wready,
  // B
  input  logic [IDSIZE+2-1:0]             m_b_pl,
  input  logic                            m_bvalid,
  output logic                            m_bready,
  output logic [IDSIZE+2-1:0]             s_b_pl,
  output logic                            s_bvalid,
  input  logic                            s_bready,
  // AR
  input  logic [IDSIZE+ASIZE+LSIZE+5-1:0] s_ar_pl,
  input  logic                            s_arvalid,
  output logic                            s_arready,
  output logic [IDSIZE+ASIZE+LSIZE+5-1:0] m_ar_pl,
  output logic                            m_arvalid,
  input  logic                            m_arready,
  // R
  input  logic [IDSIZE+DSIZE+3-1:0]       m_r_pl,
  input  logic                            m_rvalid,
  output logic                            m_rready,
  output logic [IDSIZE+DSIZE+3-1:0]       s_r_pl,
  output logic                            s_rvalid,
  input  logic                            s_rready
);

  localparam int AW_W = IDSIZE + ASIZE + LSIZE + 5;
  localparam int W_W  = DSIZE + DSIZE / 8 + 1;
  localparam int B_W  = IDSIZE + 2;
  localparam int R_W  = IDSIZE + DSIZE + 3;

  localparam bit BUILD_WR = (MODE == "BOTH") || (MODE == "ONLY_WRITE");
  localparam bit BUILD_RD = (MODE == "BOTH") || (MODE == "ONLY_READ");

  generate
    if (!BUILD_WR && !BUILD_RD) begin : g_bad_mode
      $error("axi4_rdwr_pipe_stage: unsupported MODE \"%s\"", MODE);
    end
  endgenerate

  generate
    if (BUILD_WR) begin : g_wr
      axi4_skid_slice #(.WIDTH(AW_W)) u_aw (
        .clk       (axi_aclk),
        .rst_n     (axi_aresetn),
        .in_pl     (s_aw_pl),
        .in_valid  (s_awvalid),
        .in_ready  (s_awready),
        .out_pl    (m_aw_pl),
        .out_valid (m_awvalid),
        .out_ready (m_awready)
      );

      axi4_skid_slice #(.WIDTH(W_W)) u_w (
        .clk       (axi_aclk),
        .rst_n     (axi_aresetn),
        .in_pl     (s_w_pl),
        .in_valid  (s_wvalid),
        .in_ready  (s_wready),
        .out_pl    (m_w_pl),
        .out_valid (m_wvalid),
        .out_ready (m_wready)
      );

      // Response flows slave -> master.
      axi4_skid_slice #(.WIDTH(B_W)) u_b (
        .clk       (axi_aclk),
        .rst_n     (axi_aresetn),
        .in_pl     (m_b_pl),
        .in_valid  (m_bvalid),
        .in_ready  (m_bready),
        .out_pl    (s_b_pl),
        .out_valid (s_bvalid),
        .out_ready (s_bready)
      );
    end else begin : g_no_wr
      logic unused_wr;
      assign unused_wr = ^{s_aw_pl, s_awvalid, m_awready, s_w_pl, s_wvalid,
                           m_wready, m_b_pl, m_bvalid, s_bready};
      assign s_awready = 1'b0;
      assign m_aw_pl   = '0;
      assign m_awvalid = 1'b0;
      assign s_wready  = 1'b0;
      assign m_w_pl    = '0;
      assign m_wvalid  = 1'b0;
      assign m_bready  = 1'b0;
      assign s_b_pl    = '0;
      assign s_bvalid  = 1'b0;
    end
  endgenerate

  generate
    if (BUILD_RD) begin : g_rd
      axi4_skid_slice #(.WIDTH(AW_W)) u_ar (
        .clk       (axi_aclk),
        .rst_n     (axi_aresetn),
        .in_pl     (s_ar_pl),
        .in_valid  (s_arvalid),
        .in_ready  (s_arready),
        .out_pl    (m_ar_pl),
        .out_valid (m_arvalid),
        .out_ready (m_arready)
      );

      axi4_skid_slice #(.WIDTH(R_W)) u_r (
        .clk       (axi_aclk),
        .rst_n     (axi_aresetn),
        .in_pl     (m_r_pl),
        .in_valid  (m_rvalid),
        .in_ready  (m_rready),
        .out_pl    (s_r_pl),
        .out_valid (s_rvalid),
        .out_ready (s_rready)
      );
    end else begin : g_no_rd
      logic unused_rd;
      assign unused_rd = ^{s_ar_pl, s_arvalid, m_arready, m_r_pl, m_rvalid, s_rready};
      assign s_arready = 1'b0;
      assign m_ar_pl   = '0;
      assign m_arvalid = 1'b0;
      assign m_rready  = 1'b0;
      assign s_r_pl    = '0;
      assign s_rvalid  = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_axi4_rdwr_pipe_stage.sv
// Bench for axi4_rdwr_pipe_stage: each channel is modelled as a 2-deep FIFO
// (queue occupancy decides valid/ready, queue head is the expected payload).

module tb_axi4_rdwr_pipe_stage;

  localparam int IDSIZE = 4;
  localparam int ASIZE  = 32;
  localparam int LSIZE  = 8;
  localparam int DSIZE  = 64;
  localparam int AW_W   = IDSIZE + ASIZE + LSIZE + 5;
  localparam int W_W    = DSIZE + DSIZE / 8 + 1;
  localparam int B_W    = IDSIZE + 2;
  localparam int R_W    = IDSIZE + DSIZE + 3;
  localparam int NCH    = 5;
  localparam int CH_AW  = 0;
  localparam int CH_W   = 1;
  localparam int CH_AR  = 2;
  localparam int CH_B   = 3;
  localparam int CH_R   = 4;

  logic axi_aclk = 1'b0;
  logic axi_aresetn;
  always #5 axi_aclk = ~axi_aclk;

  // Channel-generic view of the main DUT.
  logic [127:0] in_pl     [NCH];
  logic         in_valid  [NCH];
  logic         out_ready [NCH];
  logic [127:0] out_pl    [NCH];
  logic         out_valid [NCH];
  logic         in_ready  [NCH];

  logic [AW_W-1:0] s_aw_pl, m_aw_pl, s_ar_pl, m_ar_pl;
  logic [W_W-1:0]  s_w_pl, m_w_pl;
  logic [B_W-1:0]  m_b_pl, s_b_pl;
  logic [R_W-1:0]  m_r_pl, s_r_pl;
  logic s_awvalid, s_awready, m_awvalid, m_awready;
  logic s_wvalid, s_wready, m_wvalid, m_wready;
  logic m_bvalid, m_bready, s_bvalid, s_bready;
  logic s_arvalid, s_arready, m_arvalid, m_arready;
  logic m_rvalid, m_rready, s_rvalid, s_rready;

  assign s_aw_pl   = in_pl[CH_AW][AW_W-1:0];
  assign s_awvalid = in_valid[CH_AW];
  assign m_awready = out_ready[CH_AW];
  assign s_w_pl    = in_pl[CH_W][W_W-1:0];
  assign s_wvalid  = in_valid[CH_W];
  assign m_wready  = out_ready[CH_W];
  assign s_ar_pl   = in_pl[CH_AR][AW_W-1:0];
  assign s_arvalid = in_valid[CH_AR];
  assign m_arready = out_ready[CH_AR];
  assign m_b_pl    = in_pl[CH_B][B_W-1:0];
  assign m_bvalid  = in_valid[CH_B];
  assign s_bready  = out_ready[CH_B];
  assign m_r_pl    = in_pl[CH_R][R_W-1:0];
  assign m_rvalid  = in_valid[CH_R];
  assign s_rready  = out_ready[CH_R];

  always_comb begin
    out_pl[CH_AW]    = 128'(m_aw_pl);
    out_valid[CH_AW] = m_awvalid;
    in_ready[CH_AW]  = s_awready;
    out_pl[CH_W]     = 128'(m_w_pl);
    out_valid[CH_W]  = m_wvalid;
    in_ready[CH_W]   = s_wready;
    out_pl[CH_AR]    = 128'(m_ar_pl);
    out_valid[CH_AR] = m_arvalid;
    in_ready[CH_AR]  = s_arready;
    out_pl[CH_B]     = 128'(s_b_pl);
    out_valid[CH_B]  = s_bvalid;
    in_ready[CH_B]   = m_bready;
    out_pl[CH_R]     = 128'(s_r_pl);
    out_valid[CH_R]  = s_rvalid;
    in_ready[CH_R]   = m_rready;
  end

  axi4_rdwr_pipe_stage #(
    .MODE("BOTH"), .IDSIZE(IDSIZE), .ASIZE(ASIZE), .LSIZE(LSIZE), .DSIZE(DSIZE)
  ) u_dut (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
    .s_aw_pl(s_aw_pl), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .m_aw_pl(m_aw_pl), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .s_w_pl(s_w_pl), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .m_w_pl(m_w_pl), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_b_pl(m_b_pl), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .s_b_pl(s_b_pl), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_ar_pl(s_ar_pl), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .m_ar_pl(m_ar_pl), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_r_pl(m_r_pl), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .s_r_pl(s_r_pl), .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  // Read-only instance: write ports driven active, outputs must stay tied off.
  logic [AW_W-1:0] ro_s_aw_pl, ro_m_aw_pl, ro_s_ar_pl, ro_m_ar_pl;
  logic [W_W-1:0]  ro_s_w_pl, ro_m_w_pl;
  logic [B_W-1:0]  ro_m_b_pl, ro_s_b_pl;
  logic [R_W-1:0]  ro_m_r_pl, ro_s_r_pl;
  logic ro_s_awvalid, ro_s_awready, ro_m_awvalid, ro_m_awready;
  logic ro_s_wvalid, ro_s_wready, ro_m_wvalid, ro_m_wready;
  logic ro_m_bvalid, ro_m_bready, ro_s_bvalid, ro_s_bready;
  logic ro_s_arvalid, ro_s_arready, ro_m_arvalid, ro_m_arready;
  logic ro_m_rvalid, ro_m_rready, ro_s_rvalid, ro_s_rready;

  axi4_rdwr_pipe_stage #(
    .MODE("ONLY_READ"), .IDSIZE(IDSIZE), .ASIZE(ASIZE), .LSIZE(LSIZE), .DSIZE(DSIZE)
  ) u_ro (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
    .s_aw_pl(ro_s_aw_pl), .s_awvalid(ro_s_awvalid), .s_awready(ro_s_awready),
    .m_aw_pl(ro_m_aw_pl), .m_awvalid(ro_m_awvalid), .m_awready(ro_m_awready),
    .s_w_pl(ro_s_w_pl), .s_wvalid(ro_s_wvalid), .s_wready(ro_s_wready),
    .m_w_pl(ro_m_w_pl), .m_wvalid(ro_m_wvalid), .m_wready(ro_m_wready),
    .m_b_pl(ro_m_b_pl), .m_bvalid(ro_m_bvalid), .m_bready(ro_m_bready),
    .s_b_pl(ro_s_b_pl), .s_bvalid(ro_s_bvalid), .s_bready(ro_s_bready),
    .s_ar_pl(ro_s_ar_pl), .s_arvalid(ro_s_arvalid), .s_arready(ro_s_arready),
    .m_ar_pl(ro_m_ar_pl), .m_arvalid(ro_m_arvalid), .m_arready(ro_m_arready),
    .m_r_pl(ro_m_r_pl), .m_rvalid(ro_m_rvalid), .m_rready(ro_m_rready),
    .s_r_pl(ro_s_r_pl), .s_rvalid(ro_s_rvalid), .s_rready(ro_s_rready)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: per-channel FIFO contents and traffic counters.
  logic [127:0] mbuf [NCH][64];
  int head [NCH];
  int cnt  [NCH];
  int n_in [NCH];
  int n_out [NCH];
  int n_last_out [NCH];
  logic last_fin [NCH];
  string cname [NCH] = '{"aw", "w", "ar", "b", "r"};
  int width [NCH] = '{AW_W, W_W, AW_W, B_W, R_W};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] rand_pl(input int w);
    logic [127:0] v;
    v = {$urandom, $urandom, $urandom, $urandom};
    for (int i = w; i < 128; i++) v[i] = 1'b0;
    return v;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      head[c] = 0;
      cnt[c] = 0;
      last_fin[c] = 1'b0;
    end
  endtask

  task automatic check_model();
    for (int c = 0; c < NCH; c++) begin
      check({cname[c], "_valid"}, 128'(out_valid[c]), 128'(cnt[c] > 0));
      check({cname[c], "_ready"}, 128'(in_ready[c]), 128'(cnt[c] < 2));
      if (cnt[c] > 0) check({cname[c], "_pl"}, out_pl[c], mbuf[c][head[c]]);
    end
  endtask

  // One clock: compare at negedge, record handshakes, update model at posedge.
  // Called and returns at posedge+1, where the caller drives the next inputs.
  task automatic step();
    logic fin [NCH];
    logic fout [NCH];
    @(negedge axi_aclk);
    check_model();
    for (int c = 0; c < NCH; c++) begin
      fin[c]  = in_valid[c] && in_ready[c];
      fout[c] = out_valid[c] && out_ready[c];
      if (fout[c] && (c == CH_W || c == CH_R) && out_pl[c][0]) n_last_out[c]++;
    end
    @(posedge axi_aclk);
    for (int c = 0; c < NCH; c++) begin
      if (fout[c]) begin
        n_out[c]++;
        if (cnt[c] > 0) begin
          head[c] = (head[c] + 1) % 64;
          cnt[c]--;
        end
      end
      if (fin[c]) begin
        n_in[c]++;
        if (cnt[c] < 64) begin
          mbuf[c][(head[c] + cnt[c]) % 64] = in_pl[c];
          cnt[c]++;
        end
      end
      last_fin[c] = fin[c];
    end
    #1;
  endtask

  task automatic check_ro_tieoffs();
    check("ro_m_awvalid", 128'(ro_m_awvalid), 128'(0));
    check("ro_s_awready", 128'(ro_s_awready), 128'(0));
    check("ro_m_aw_pl", 128'(ro_m_aw_pl), 128'(0));
    check("ro_m_wvalid", 128'(ro_m_wvalid), 128'(0));
    check("ro_s_wready", 128'(ro_s_wready), 128'(0));
    check("ro_m_w_pl", 128'(ro_m_w_pl), 128'(0));
    check("ro_m_bready", 128'(ro_m_bready), 128'(0));
    check("ro_s_bvalid", 128'(ro_s_bvalid), 128'(0));
    check("ro_s_b_pl", 128'(ro_s_b_pl), 128'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d [3];
    int base_in [NCH];
    int base_out [NCH];
    int base_last [NCH];
    int cyc;
    bit busy;

    axi_aresetn = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      in_pl[c] = '0;
      in_valid[c] = 1'b0;
      out_ready[c] = 1'b0;
      n_in[c] = 0;
      n_out[c] = 0;
      n_last_out[c] = 0;
    end
    model_clear();
    ro_s_aw_pl = '1; ro_s_awvalid = 1'b1; ro_m_awready = 1'b1;
    ro_s_w_pl  = '1; ro_s_wvalid  = 1'b1; ro_m_wready  = 1'b1;
    ro_m_b_pl  = '1; ro_m_bvalid  = 1'b1; ro_s_bready  = 1'b1;
    ro_s_ar_pl = AW_W'(49'h123); ro_s_arvalid = 1'b1; ro_m_arready = 1'b0;
    ro_m_r_pl  = '0; ro_m_rvalid  = 1'b0; ro_s_rready  = 1'b1;

    // Reset state.
    #12;
    for (int c = 0; c < NCH; c++) begin
      check({"rst_", cname[c], "_valid"}, 128'(out_valid[c]), 128'(0));
      check({"rst_", cname[c], "_ready"}, 128'(in_ready[c]), 128'(1));
      check({"rst_", cname[c], "_pl"}, out_pl[c], 128'(0));
    end
    check_ro_tieoffs();
    check("ro_rst_arready", 128'(ro_s_arready), 128'(1));
    check("ro_rst_arvalid", 128'(ro_m_arvalid), 128'(0));
    @(posedge axi_aclk);
    #1;
    axi_aresetn = 1'b1;
    repeat (4) step();

    // Streaming AR: one beat per clock, each visible one clock later.
    out_ready[CH_AR] = 1'b1;
    base_in[CH_AR] = n_in[CH_AR];
    base_out[CH_AR] = n_out[CH_AR];
    for (int k = 0; k < 16; k++) begin
      in_valid[CH_AR] = 1'b1;
      in_pl[CH_AR] = 128'({4'd1, 32'(32'h1000 + k), 8'd0, 3'd3, 2'd1});
      step();
      check("ar_stream_addr", 128'(m_ar_pl[44:13]), 128'(32'h1000 + k));
      check("ar_stream_valid", 128'(m_arvalid), 128'(1));
    end
    check("ar_stream_in16", 128'(n_in[CH_AR] - base_in[CH_AR]), 128'(16));
    in_valid[CH_AR] = 1'b0;
    step();
    check("ar_stream_out16", 128'(n_out[CH_AR] - base_out[CH_AR]), 128'(16));

    // W stall: two beats absorbed, then back-pressure; release drains in order.
    d[0] = 128'({64'hD000_0000_0000_0000, 8'hFF, 1'b0});
    d[1] = 128'({64'hD111_0000_0000_0001, 8'h0F, 1'b0});
    d[2] = 128'({64'hD222_0000_0000_0002, 8'hF0, 1'b1});
    out_ready[CH_W] = 1'b0;
    in_valid[CH_W] = 1'b1;
    in_pl[CH_W] = d[0];
    step();
    check("w_stall_ready_after_d0", 128'(s_wready), 128'(1));
    check("w_stall_pl_d0", 128'(m_w_pl), d[0]);
    in_pl[CH_W] = d[1];
    step();
    check("w_stall_ready_after_d1", 128'(s_wready), 128'(0));
    in_pl[CH_W] = d[2];
    repeat (3) begin
      step();
      check("w_stall_ready_held", 128'(s_wready), 128'(0));
      check("w_stall_pl_stable", 128'(m_w_pl), d[0]);
      check("w_stall_valid", 128'(m_wvalid), 128'(1));
    end
    out_ready[CH_W] = 1'b1;
    step();
    check("w_drain_pl_d1", 128'(m_w_pl), d[1]);
    check("w_drain_ready", 128'(s_wready), 128'(1));
    step();
    check("w_drain_pl_d2", 128'(m_w_pl), d[2]);
    check("w_drain_valid_d2", 128'(m_wvalid), 128'(1));
    in_valid[CH_W] = 1'b0;
    step();
    check("w_drain_empty", 128'(m_wvalid), 128'(0));

    // B response upstream, held while s_bready is low.
    out_ready[CH_B] = 1'b0;
    in_valid[CH_B] = 1'b1;
    in_pl[CH_B] = 128'({4'd3, 2'b10});
    step();
    in_valid[CH_B] = 1'b0;
    check("b_pl_lat", 128'(s_b_pl), 128'(6'h0E));
    check("b_valid_lat", 128'(s_bvalid), 128'(1));
    repeat (3) begin
      step();
      check("b_hold_pl", 128'(s_b_pl), 128'(6'h0E));
      check("b_hold_valid", 128'(s_bvalid), 128'(1));
    end
    out_ready[CH_B] = 1'b1;
    step();
    check("b_consumed", 128'(s_bvalid), 128'(0));

    // Random valid/ready on all channels, 1000 beats each; W/R bursts of 8.
    for (int c = 0; c < NCH; c++) begin
      base_in[c] = n_in[c];
      base_out[c] = n_out[c];
      base_last[c] = n_last_out[c];
      in_valid[c] = 1'b0;
    end
    cyc = 0;
    busy = 1'b1;
    while (busy && cyc < 20000) begin
      for (int c = 0; c < NCH; c++) begin
        if (!(in_valid[c] && !last_fin[c])) begin
          int idx;
          idx = n_in[c] - base_in[c];
          if (idx < 1000 && $urandom_range(0, 99) < 60) begin
            in_valid[c] = 1'b1;
            in_pl[c] = rand_pl(width[c]);
            if (c == CH_W || c == CH_R) in_pl[c][0] = (idx % 8 == 7);
          end else begin
            in_valid[c] = 1'b0;
          end
        end
        out_ready[c] = ($urandom_range(0, 99) < 70);
      end
      step();
      cyc++;
      busy = 1'b0;
      for (int c = 0; c < NCH; c++) if (n_in[c] - base_in[c] < 1000) busy = 1'b1;
    end
    for (int c = 0; c < NCH; c++) begin
      in_valid[c] = 1'b0;
      out_ready[c] = 1'b1;
    end
    repeat (4) step();
    for (int c = 0; c < NCH; c++) begin
      check({"rand_in_", cname[c]}, 128'(n_in[c] - base_in[c]), 128'(1000));
      check({"rand_out_", cname[c]}, 128'(n_out[c] - base_out[c]), 128'(1000));
    end
    check("rand_wlast", 128'(n_last_out[CH_W] - base_last[CH_W]), 128'(125));
    check("rand_rlast", 128'(n_last_out[CH_R] - base_last[CH_R]), 128'(125));

    // Reset in the middle of an R burst.
    out_ready[CH_R] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid[CH_R] = 1'b1;
      in_pl[CH_R] = rand_pl(R_W);
      step();
    end
    in_valid[CH_R] = 1'b0;
    check("r_burst_valid", 128'(s_rvalid), 128'(1));
    #2;
    axi_aresetn = 1'b0;
    #1;
    check("r_rst_valid", 128'(s_rvalid), 128'(0));
    check("r_rst_ready", 128'(m_rready), 128'(1));
    check("r_rst_pl", 128'(s_r_pl), 128'(0));
    model_clear();
    repeat (2) @(posedge axi_aclk);
    #1;
    axi_aresetn = 1'b1;
    base_out[CH_R] = n_out[CH_R];
    base_last[CH_R] = n_last_out[CH_R];
    out_ready[CH_R] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_valid[CH_R] = 1'b1;
      in_pl[CH_R] = rand_pl(R_W);
      in_pl[CH_R][0] = (k == 7);
      step();
    end
    in_valid[CH_R] = 1'b0;
    repeat (2) step();
    check("r_post_rst_beats", 128'(n_out[CH_R] - base_out[CH_R]), 128'(8));
    check("r_post_rst_last", 128'(n_last_out[CH_R] - base_last[CH_R]), 128'(1));

    // Read-only instance: read half alive, write half tied off.
    check_ro_tieoffs();
    check("ro_m_arvalid", 128'(ro_m_arvalid), 128'(1));
    check("ro_m_ar_pl", 128'(ro_m_ar_pl), 128'(49'h123));
    check("ro_s_arready_full", 128'(ro_s_arready), 128'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
